// File: rtl/seq_pkg.sv
// Shared definitions for the step-sequencer pattern player:
// FSM state encoding, the stored step word layout and default widths.
package seq_pkg;

  // Default geometry of a pattern bank
  localparam int STEPS_DEF  = 16;
  localparam int NOTE_W_DEF = 7;
  localparam int DIV_W_DEF  = 16;

  // Player phases: wait for run, issue read, capture word, sound step
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Layout of one pattern RAM word as written by the editor: {valid, note}
  typedef struct packed {
    logic                  valid;
    logic [NOTE_W_DEF-1:0] note;
  } step_word_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag. Used by the step player for the
// tempo tick and the gate length. A load wins over a decrement, and the
// count saturates at zero instead of wrapping.
module seq_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: load, otherwise step down while above zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_step_player.sv
// Step sequencer pattern player. Walks the pattern RAM one step at a time:
// FETCH issues a one-cycle read, LATCH captures the returned word into
// note/gate/step_idx, and HOLD waits out the rest of the step period.
// Step period is tempo_div + 3 cycles. The gate is dropped for one cycle
// between steps so that back-to-back notes always retrigger the voice.
//
// Optional build macro: SEQ_PLAYER_LOOP_EN adds the loop_len port, which sets
// the last step index before wrapping to 0. Without it the whole bank plays.
module seq_step_player
  import seq_pkg::*;
#(
  parameter int STEPS  = STEPS_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  localparam int ADDR_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DIV_W-1:0]  tempo_div,
  input  logic [DIV_W-1:0]  gate_len,
`ifdef SEQ_PLAYER_LOOP_EN
  input  logic [ADDR_W-1:0] loop_len,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [NOTE_W:0]   rd_data,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic              step_pulse,
  output logic [ADDR_W-1:0] step_idx
);

  state_t            state;
  logic [ADDR_W-1:0] step_cnt;
  logic [ADDR_W-1:0] next_step;

  logic              word_valid;
  logic [NOTE_W-1:0] word_note;

  logic              tick_load;
  logic              tick_dec;
  logic [DIV_W-1:0]  tick_count;
  logic              tick_zero;

  logic              gate_load;
  logic              gate_dec;
  logic [DIV_W-1:0]  gate_count;
  logic              gate_zero;
  logic              gate_last;

  // Only the tick counter's zero flag steers the FSM
  logic              unused_tick_bits;
  assign unused_tick_bits = ^tick_count;

  assign word_valid = rd_data[NOTE_W];
  assign word_note  = rd_data[NOTE_W-1:0];

  // Step after the one being latched; wraps at the bank end or the loop end.
  // A loop shortened below the current position sends the next step to 0.
  always_comb begin
    next_step = step_cnt + ADDR_W'(1);
`ifdef SEQ_PLAYER_LOOP_EN
    if (step_cnt >= loop_len) begin
      next_step = '0;
    end
`endif
  end

  // Both counters reload at LATCH so tempo/gate changes land on a step start
  assign tick_load = run && (state == LATCH);
  assign gate_load = run && (state == LATCH);
  assign tick_dec  = run && (state == HOLD);
  assign gate_dec  = run && (state == HOLD) && !gate_zero;

  // Gate falls on the edge where the gate counter leaves 1, giving exactly
  // gate_len high cycles counted from the LATCH edge
  assign gate_last = (state == HOLD) && (gate_count == DIV_W'(1));

  seq_down_counter #(
    .W(DIV_W)
  ) u_tick_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (tick_load),
    .load_val (tempo_div),
    .dec      (tick_dec),
    .count    (tick_count),
    .zero     (tick_zero)
  );

  seq_down_counter #(
    .W(DIV_W)
  ) u_gate_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gate_load),
    .load_val (gate_len),
    .dec      (gate_dec),
    .count    (gate_count),
    .zero     (gate_zero)
  );

  // Player FSM with registered outputs; dropping run returns to IDLE from
  // any state, abandoning a read in flight and clearing all outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step_cnt   <= '0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      note       <= '0;
      gate       <= 1'b0;
      step_pulse <= 1'b0;
      step_idx   <= '0;
    end else begin
      rd_en      <= 1'b0;
      step_pulse <= 1'b0;
      if (!run) begin
        state    <= IDLE;
        step_cnt <= '0;
        rd_addr  <= '0;
        note     <= '0;
        gate     <= 1'b0;
        step_idx <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= FETCH;
            rd_en   <= 1'b1;
            rd_addr <= step_cnt;
          end
          FETCH: begin
            // Read is in flight; release the gate for the retrigger gap
            state <= LATCH;
            gate  <= 1'b0;
          end
          LATCH: begin
            if (word_valid) begin
              note <= word_note;
            end
            gate       <= word_valid && (gate_len != '0);
            step_pulse <= 1'b1;
            step_idx   <= rd_addr;
            step_cnt   <= next_step;
            state      <= HOLD;
          end
          HOLD: begin
            if (gate_last) begin
              gate <= 1'b0;
            end
            if (tick_zero) begin
              state   <= FETCH;
              rd_en   <= 1'b1;
              rd_addr <= step_cnt;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
